// File: rtl/xor_share_pkg.sv
// Shared types and constants for the bit-serial XOR sequencer.
// No logic; state encoding, requester IDs and counter sizing helper.
// Imported by every module of the block.
package xor_share_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    // Bit counter must hold WIDTH-1; a 1-bit result still needs a 1-bit counter.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/nand_xor_cell.sv
// Single-bit XOR built from four 2-input NAND gates.
// Latency: purely combinational, zero cycles.
// Backpressure: none, stateless.
module nand_xor_cell (
    input  logic a,
    input  logic b,
    output logic y
);

    logic n_ab;
    logic n_a;
    logic n_b;

    assign n_ab = ~(a & b);
    assign n_a  = ~(a & n_ab);
    assign n_b  = ~(b & n_ab);
    assign y    = ~(n_a & n_b);

endmodule

// File: rtl/xor_share_sequencer.sv
// Two-requester round-robin front end feeding one shared bit-serial XOR cell.
// Latency: result valid WIDTH cycles after the accept edge; WIDTH+2 cycles per op minimum.
// Backpressure: result held stable while res_ready is low; no request accepted until drained.
module xor_share_sequencer
    import xor_share_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_parity,
    output logic             res_id,
    output logic             busy
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state_q;
    state_t           state_d;
    logic             last_grant_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic             par_q;
    logic             id_q;
    logic [CW-1:0]    cnt_q;

    logic             grant0;
    logic             grant1;
    logic             accept;
    logic             shift_en;
    logic             last_bit;
    logic             cell_y;
    logic [WIDTH:0]   res_ext;

    // On a tie the requester that was not served last wins.
    assign grant0 = req0_valid && (!req1_valid || (last_grant_q == REQ1));
    assign grant1 = req1_valid && (!req0_valid || (last_grant_q == REQ0));

    assign req0_ready = (state_q == IDLE) && grant0 && rst_n;
    assign req1_ready = (state_q == IDLE) && grant1 && rst_n;
    assign accept     = req0_ready || req1_ready;

    assign shift_en = (state_q == SHIFT);
    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    nand_xor_cell u_cell (
        .a (a_q[0]),
        .b (b_q[0]),
        .y (cell_y)
    );

    // Cell output enters at the MSB so the word is LSB-aligned after WIDTH shifts.
    assign res_ext = {cell_y, res_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SHIFT;
            SHIFT:   if (last_bit) state_d = DONE;
            DONE:    if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= REQ1;
            a_q          <= '0;
            b_q          <= '0;
            res_q        <= '0;
            par_q        <= 1'b0;
            id_q         <= REQ0;
            cnt_q        <= '0;
        end else if (accept) begin
            a_q          <= req0_ready ? req0_a : req1_a;
            b_q          <= req0_ready ? req0_b : req1_b;
            id_q         <= req0_ready ? REQ0 : REQ1;
            last_grant_q <= req0_ready ? REQ0 : REQ1;
            res_q        <= '0;
            par_q        <= 1'b0;
            cnt_q        <= '0;
        end else if (shift_en) begin
            a_q   <= a_q >> 1;
            b_q   <= b_q >> 1;
            res_q <= res_ext[WIDTH:1];
            par_q <= par_q ^ cell_y;
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign res_valid  = (state_q == DONE);
    assign res_data   = res_q;
    assign res_parity = par_q;
    assign res_id     = id_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: doc/xor_share_sequencer.md
# xor_share_sequencer

Bit-serial XOR engine that shares a single 1-bit NAND-built XOR cell between two requesters. It accepts one WIDTH-bit operand pair at a time through a valid/ready handshake and arbitrates round-robin when both requesters are pending. It streams the operands LSB-first through the cell, assembles the result word and its parity, and presents them on a valid/ready result port tagged with the requester ID. The block sits between operand producers and any consumer of bitwise-difference/parity results, replacing per-requester WIDTH-wide XOR arrays.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 1..64.
- clk  in  1  rising-edge clock, single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 holds an operand pair.
- req0_ready  out  1  requester 0 pair accepted this cycle when valid.
- req0_a, req0_b  in  WIDTH  requester 0 operands.
- req1_valid, req1_ready, req1_a, req1_b: same as requester 0, for requester 1.
- res_valid  out  1  result available.
- res_ready  in  1  consumer takes the result.
- res_data  out  WIDTH  bitwise a XOR b.
- res_parity  out  1  XOR-reduction of res_data.
- res_id  out  1  requester that issued the operation.
- busy  out  1  high in SHIFT or DONE.

## Operation
- FSM states: IDLE, SHIFT, DONE. The reset state is IDLE.
- IDLE:
  - grant_i requires req_i_valid.
  - If only one requester is valid, that requester is granted.
  - If both are valid, the grant goes to the requester that is not last_grant.
  - req_i_ready = (state==IDLE) && grant_i && rst_n. This is combinational.
- Accept edge:
  - Capture a and b into shift registers.
  - Capture res_id.
  - Set last_grant to the granted requester.
  - Clear the bit counter, the result register and the parity.
  - Transition to SHIFT.
- SHIFT, once per cycle:
  - The cell computes a[0]^b[0].
  - The operand registers shift right.
  - The cell output shifts into the result MSB, so after WIDTH shifts the result is aligned LSB-first.
  - parity ^= cell output; counter++.
  - On the edge where the counter reaches WIDTH-1, transition to DONE.
- DONE:
  - res_valid=1; res_data, res_parity and res_id are stable.
  - On an edge with res_ready=1, transition to IDLE.
  - No request is accepted in DONE.
- last_grant resets to 1, so requester 0 wins the first tie.
- Counter width is $clog2(WIDTH), with a minimum of 1. WIDTH=1 gives exactly one SHIFT cycle.
- Reset values:
  - res_valid=0, res_data=0, res_parity=0, res_id=0, busy=0.
  - req0_ready=0 and req1_ready=0 while rst_n is low.
- Reset mid-operation: all state clears immediately and the in-flight operation is discarded. No res_valid is produced for it.
- Requester operands need only be stable during the accept cycle. Later changes have no effect.
- A valid deasserted before ready is permitted. Arbitration then re-evaluates in the same cycle.

## Timing
- Accept at edge E0. Shifting occurs at edges E1..EW.
- res_valid rises after edge EW, i.e. WIDTH cycles after the accept edge.
- The result handshake at edge Ed returns the FSM to IDLE. The earliest next accept is at edge Ed+1.
- Minimum period per operation: WIDTH+2 cycles.
- res_valid is held indefinitely under back-pressure. Outputs must not change while res_valid=1 and res_ready=0.
- There are no combinational paths from res_ready to any output, or from req valids to res_*.

## Structure
- Shared package xor_share_pkg holds:
  - State encoding constants IDLE=2'd0, SHIFT=2'd1, DONE=2'd2.
  - The requester-ID constants.
- Sub-module nand_xor_cell: 2-input XOR composed only of 2-input NAND-equivalent assigns (four gates), output = a^b.
  - It is instantiated exactly once.
  - It is the only place XOR of data bits is computed.
- The FSM, arbiter, shift registers and counter are built in one module.

## Test plan
- Single op, WIDTH=8: req0 a=8'hA5, b=8'h3C.
  - Expect res_data=8'h99, res_parity=0, res_id=0.
  - res_valid rises 8 cycles after the accept edge.
- Parity, run sequentially: a=8'h01, b=8'h00.
  - Expect res_data=8'h01, res_parity=1.
- Tie after reset: req0 and req1 both valid.
  - req0 is served first; req1 is accepted on the first IDLE cycle after the req0 result handshake.
  - A following tie grants req0.
- Back-pressure: hold res_ready=0 for 5 cycles in DONE.
  - res_valid, res_data and res_id stay constant.
  - req0_ready and req1_ready stay 0.
  - busy=1 throughout.
- Reset mid-op: assert rst_n=0 three cycles into SHIFT.
  - Outputs are zero immediately.
  - After release the FSM is in IDLE and no result appears.
  - The next request completes correctly.
- WIDTH=1 truth table: pairs (1,0), (0,1), (0,0), (1,1).
  - Expect res_data 1, 1, 0, 0 and parity equal to res_data.
  - Each result arrives 1 cycle after accept.
